tt_um_clk_div_prog: RTL and testbench
=====================================

# tt_um_clk_div_prog

Programmable multi-channel clock-enable divider: the parametrised successor to the fixed cascaded ÷2/÷4/÷8/÷16 divider. It generates CHANNELS independent divided outputs from one clock.
- Each channel has a runtime-programmable ratio, a 1-cycle tick strobe and glitch-free reconfiguration at period boundaries.
- A registered AND-combine output is optional.
- Everything runs in the `clk` domain; no derived clocks drive flops.

## Interface
Parameters:
- `CHANNELS`, 4: number of divider channels (1..16).
- `DIV_W`, 8: divisor width; ratio range 0..2^DIV_W-1.
- `COMB_MASK`, 4'b0101: channels ANDed into `Y` (width CHANNELS).

Ports:
- `clk`  in  1  sole clock; all state on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  global count enable.
- `cfg_valid`  in  1  divisor write request.
- `cfg_ready`  out  1  write accepted when `cfg_valid & cfg_ready`.
- `cfg_chan`  in  CH_W  target channel; CH_W = max(1, clog2(CHANNELS)).
- `cfg_div`  in  DIV_W  new divisor D.
- `clk_div`  out  CHANNELS  per-channel divided level (registered).
- `tick`  out  CHANNELS  per-channel 1-cycle strobe, coincident with the `clk_div` rising edge.
- `Y`  out  1  registered AND of masked `clk_div` values.

## Operation
- Per-channel state:
  - `div_r`: active divisor, reset value 2.
  - `cnt`: DIV_W bits, reset value 0.
  - `shadow`: pending divisor.
  - `pend`: pending flag, reset value 0.
- Enabled edge (`ena`=1, D>=1):
  - Compute cnt_n = (cnt == D-1) ? 0 : cnt+1, then `cnt <= cnt_n`.
  - `tick <= (cnt_n == 0)`.
  - `clk_div <= (cnt_n < H)`, where H = ceil(D/2).
- D=1: `tick` is 1 every enabled cycle and `clk_div` is held at 1.
- D=0 (channel off): `cnt`, `clk_div` and `tick` are forced to 0.
- `ena`=0: `cnt` and `clk_div` hold; `tick` is forced to 0.
- `cfg_ready = !pend[cfg_chan]`. A write to `cfg_chan >= CHANNELS` is accepted and discarded.
- Accepted write, target channel active (D>=1):
  - `shadow <= cfg_div`, `pend <= 1`.
  - The ratio is applied on the first subsequent enabled edge where cnt_n==0: `div_r <= shadow`, `cnt <= 0`, `pend <= 0`.
  - The outputs on that edge still follow the old ratio's wrap (`tick`=1, `clk_div`=1), so the output period is never truncated.
- Accepted write, target channel off (D=0): applied on the next edge regardless of `ena`, with `cnt`=0 and outputs 0.
- A write accepted on the same edge as a wrap is not applied on that edge; it takes effect at the next wrap.
- `Y <= &(next clk_div | ~COMB_MASK)` when COMB_MASK != 0. An all-zero mask gives `Y`=0.

## Timing
- Reset values (immediate, asynchronous): `clk_div`=0, `tick`=0, `Y`=0, `cfg_ready`=1, every `div_r`=2, `pend`=0.
- First enabled edge after reset: cnt_n=1, all outputs stay 0.
  - Second enabled edge: ÷2 channels show `tick`=1 and `clk_div`=1.
- Output latency is 1 edge from the count decision; `clk_div`, `tick` and `Y` change on the same edge.
- Write handshake: single cycle; `cfg_ready` deasserts on the edge after acceptance and reasserts on the edge where the ratio is applied.
- Reset during operation drops all pending writes and restarts every channel at ÷2.

## Configuration
- `CLKDIV_COMBINE_EN` defined: the `Y` combine logic and register are built as described.
- `CLKDIV_COMBINE_EN` undefined: `Y` is tied to 0, no combine flop exists, and the port remains.

## Structure
- Package `clkdiv_pkg` holds:
  - constant `CLKDIV_DIV_RST` = 2;
  - function `clkdiv_half(D)` returning ceil(D/2);
  - CH_W computation helper.
- Sub-module `clkdiv_chan`: one channel (counter, shadow/pend, output regs).
  - The top instantiates CHANNELS copies, muxes `cfg_ready` by `cfg_chan`, and owns `Y`.

## Test plan
- Reset release, `ena`=1, no writes -> every channel `clk_div` = 0,1,0,1...; `tick`=1 on enabled edges 2,4,6.
- Mid-period write ch1 D=3 -> `cfg_ready`=0 until the next ch1 wrap; thereafter ch1 `clk_div` = 1,1,0 repeating and `tick` every 3rd cycle; ch0 unaffected.
- Write ch2 D=0 -> ch2 `clk_div`/`tick` = 0 on the next edge. Write D=1 -> `tick`=1 every cycle, `clk_div`=1.
- `ena`=0 for 5 cycles mid-period at D=5 -> outputs hold, `tick`=0; the count resumes from the held value (no skipped phase).
- `rst_n` asserted while ch3 has a pending write -> outputs 0 immediately; after release ch3 runs ÷2 and `cfg_ready`=1.
- `CLKDIV_COMBINE_EN`, COMB_MASK=0101, ch0 D=2, ch2 D=8 -> `Y` high exactly 2 cycles per 8. Without the macro -> `Y` is constantly 0.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock-enable divider.
package clkdiv_pkg;

  // Divisor every channel starts with after reset
  localparam int unsigned CLKDIV_DIV_RST = 2;

  // High-phase length of a period of d cycles: ceil(d/2)
  function automatic int unsigned clkdiv_half(input int unsigned d);
    return (d + 1) / 2;
  endfunction

  // Channel-select width: max(1, clog2(n))
  function automatic int unsigned clkdiv_ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, shadow divisor with pending flag,
// registered level and tick outputs. The new ratio only lands on a wrap so
// an output period is never cut short.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pend,
  output logic             clk_div,
  output logic             tick,
  output logic             clk_div_nxt_c
);

  logic [DIV_W-1:0] div_r, cnt, shadow;
  logic [DIV_W-1:0] div_n, cnt_n, shadow_n, cnt_step;
  logic [DIV_W:0]   half;
  logic             pend_n, tick_n, wrap;

  // Next-state: count, wrap detection, deferred ratio update
  always_comb begin
    div_n         = div_r;
    cnt_n         = cnt;
    shadow_n      = shadow;
    pend_n        = pend;
    tick_n        = 1'b0;
    clk_div_nxt_c = clk_div;
    cnt_step      = (cnt == div_r - DIV_W'(1)) ? '0 : cnt + DIV_W'(1);
    wrap          = (cnt_step == '0);
    half          = (DIV_W+1)'(clkdiv_half(32'(div_r)));

    if (div_r == '0) begin
      // Channel off: everything parked at 0; a pending ratio lands immediately
      cnt_n         = '0;
      clk_div_nxt_c = 1'b0;
      if (pend) begin
        div_n  = shadow;
        pend_n = 1'b0;
      end
    end else if (ena) begin
      cnt_n         = cnt_step;
      tick_n        = wrap;
      clk_div_nxt_c = ({1'b0, cnt_step} < half);
      if (pend && wrap) begin
        div_n  = shadow;
        cnt_n  = '0;
        pend_n = 1'b0;
      end
    end

    // Writes are only accepted while nothing is pending
    if (wr) begin
      shadow_n = wr_div;
      pend_n   = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r   <= DIV_W'(CLKDIV_DIV_RST);
      cnt     <= '0;
      shadow  <= '0;
      pend    <= 1'b0;
      clk_div <= 1'b0;
      tick    <= 1'b0;
    end else begin
      div_r   <= div_n;
      cnt     <= cnt_n;
      shadow  <= shadow_n;
      pend    <= pend_n;
      clk_div <= clk_div_nxt_c;
      tick    <= tick_n;
    end
  end

endmodule

// File: rtl/tt_um_clk_div_prog.sv
// Programmable multi-channel clock-enable divider.
// Optional feature macro: CLKDIV_COMBINE_EN builds the registered AND-combine
// output Y; without it Y is tied low.
module tt_um_clk_div_prog
  import clkdiv_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W = 8,
  parameter logic [CHANNELS-1:0] COMB_MASK = CHANNELS'(4'b0101),
  localparam int unsigned CH_W = clkdiv_ch_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] clk_div,
  output logic [CHANNELS-1:0] tick,
  output logic                Y
);

  logic [CHANNELS-1:0] pend;
  logic [CHANNELS-1:0] clk_div_nxt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic wr;
    assign wr = cfg_valid && (cfg_chan == CH_W'(i)) && !pend[i];

    clkdiv_chan #(.DIV_W(DIV_W)) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .wr            (wr),
      .wr_div        (cfg_div),
      .pend          (pend[i]),
      .clk_div       (clk_div[i]),
      .tick          (tick[i]),
      .clk_div_nxt_c (clk_div_nxt[i])
    );
  end

  // Ready follows the selected channel; out-of-range selects always accept
  always_comb begin
    cfg_ready = 1'b1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_chan == CH_W'(i)) cfg_ready = !pend[i];
    end
  end

`ifdef CLKDIV_COMBINE_EN
  // Combine register sees the same next levels that clk_div is about to take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Y <= 1'b0;
    else        Y <= (COMB_MASK != '0) && (&(clk_div_nxt | ~COMB_MASK));
  end
`else
  logic unused_comb;
  assign unused_comb = ^{clk_div_nxt, COMB_MASK};
  assign Y = 1'b0;
`endif

endmodule

// File: tb/tb_tt_um_clk_div_prog.sv
// Randomised and directed bench for tt_um_clk_div_prog with a phase-based
// reference model of each channel.
module tb_tt_um_clk_div_prog;

  localparam int unsigned CH    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned CW    = 2;
  localparam logic [CH-1:0] MASK = 4'b0101;

  logic          clk, rst_n, ena, cfg_valid, cfg_ready, Y;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic [CH-1:0] clk_div, tick;

  int checks = 0;
  int errors = 0;

  // Model: each channel is a phase position within a period of length m_d
  int            m_d   [CH];
  int            m_pos [CH];
  int            m_sh  [CH];
  bit            m_pend[CH];
  logic [CH-1:0] e_clk, e_tick;
  logic          e_y;

  tt_um_clk_div_prog #(.CHANNELS(CH), .DIV_W(DW), .COMB_MASK(MASK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_div   (cfg_div),
    .clk_div   (clk_div),
    .tick      (tick),
    .Y         (Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_ready();
    return !m_pend[int'(cfg_chan)];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d[c] = 2; m_pos[c] = 0; m_sh[c] = 0; m_pend[c] = 0;
    end
    e_clk = '0; e_tick = '0; e_y = 1'b0;
  endtask

  // Advance model by one edge using the current inputs, then clock the DUT
  task automatic cyc();
    logic [CH-1:0] nclk, ntick;
    for (int c = 0; c < CH; c++) begin
      bit acc;
      acc = cfg_valid && (int'(cfg_chan) == c) && !m_pend[c];
      nclk[c] = 1'b0; ntick[c] = 1'b0;
      if (m_d[c] == 0) begin
        m_pos[c] = 0;
        if (m_pend[c]) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
      end else if (ena) begin
        m_pos[c] = (m_pos[c] + 1) % m_d[c];
        ntick[c] = (m_pos[c] == 0);
        nclk[c]  = (m_pos[c] < (m_d[c] + 1) / 2);
        if (m_pend[c] && m_pos[c] == 0) begin m_d[c] = m_sh[c]; m_pend[c] = 0; end
      end else begin
        nclk[c] = e_clk[c];
      end
      if (acc) begin m_sh[c] = int'(cfg_div); m_pend[c] = 1; end
    end
    @(posedge clk); #1;
    e_clk = nclk; e_tick = ntick;
`ifdef CLKDIV_COMBINE_EN
    e_y = (MASK != '0) && ((nclk & MASK) == MASK);
`else
    e_y = 1'b0;
`endif
  endtask

  task automatic do_write(input int ch, input int d);
    int n;
    n = 0;
    cfg_chan = CW'(ch); cfg_div = DW'(d); cfg_valid = 1'b0;
    while (cfg_ready !== 1'b1 && n < 60) begin cyc(); n++; end
    if (n == 60) begin
      checks++; errors++;
      $display("FAIL write_wait ch%0d: cfg_ready=%b required 1 within 60 cycles", ch, cfg_ready);
    end
    cfg_valid = 1'b1;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ena = 1'b0; cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({clk_div, tick, Y, cfg_ready} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: clk_div=%b tick=%b Y=%b ready=%b required 0000 0000 0 1",
               clk_div, tick, Y, cfg_ready);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({clk_div, tick, Y} !== 9'h0) begin
      errors++;
      $display("FAIL reset_idle: clk_div=%b tick=%b Y=%b required zeros", clk_div, tick, Y);
    end
  endtask

  task automatic test_div2();
    ena = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++;
      if ({clk_div, tick} !== ((k % 2 == 0) ? 8'hFF : 8'h00)) begin
        errors++;
        $display("FAIL div2_edge%0d: clk_div=%b tick=%b required %s", k, clk_div, tick,
                 (k % 2 == 0) ? "1111 1111" : "0000 0000");
      end
      checks++;
      if (Y !== e_y) begin
        errors++;
        $display("FAIL div2_y edge%0d: Y=%b required %b", k, Y, e_y);
      end
    end
  endtask

  task automatic test_write_d3();
    cyc();
    do_write(1, 3);
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (cfg_ready !== exp_ready()) begin
        errors++;
        $display("FAIL d3_ready cyc%0d: ready=%b required %b", k, cfg_ready, exp_ready());
      end
      cyc();
      checks++;
      if ({clk_div, tick, Y} !== {e_clk, e_tick, e_y}) begin
        errors++;
        $display("FAIL d3_out cyc%0d: clk_div=%b tick=%b Y=%b required %b %b %b",
                 k, clk_div, tick, Y, e_clk, e_tick, e_y);
      end
    end
  endtask

  task automatic test_off_and_d1();
    do_write(2, 0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if ({clk_div, tick, Y} !== {e_clk, e_tick, e_y}) begin
        errors++;
        $display("FAIL off_out cyc%0d: clk_div=%b tick=%b Y=%b required %b %b %b",
                 k, clk_div, tick, Y, e_clk, e_tick, e_y);
      end
    end
    checks++;
    if ({clk_div[2], tick[2]} !== 2'b00) begin
      errors++;
      $display("FAIL off_ch2: clk_div=%b tick=%b required 0 0", clk_div[2], tick[2]);
    end
    do_write(2, 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      checks++;
      if ({clk_div, tick, Y} !== {e_clk, e_tick, e_y}) begin
        errors++;
        $display("FAIL d1_out cyc%0d: clk_div=%b tick=%b Y=%b required %b %b %b",
                 k, clk_div, tick, Y, e_clk, e_tick, e_y);
      end
      if (k >= 1) begin
        checks++;
        if ({clk_div[2], tick[2]} !== 2'b11) begin
          errors++;
          $display("FAIL d1_ch2 cyc%0d: clk_div=%b tick=%b required 1 1", k, clk_div[2], tick[2]);
        end
      end
    end
  endtask

  task automatic test_ena_hold();
    do_write(3, 5);
    for (int k = 0; k < 24; k++) begin
      ena = !(k >= 9 && k < 14);
      cyc();
      checks++;
      if ({clk_div, tick, Y} !== {e_clk, e_tick, e_y}) begin
        errors++;
        $display("FAIL hold_out cyc%0d ena=%b: clk_div=%b tick=%b Y=%b required %b %b %b",
                 k, ena, clk_div, tick, Y, e_clk, e_tick, e_y);
      end
      if (!ena) begin
        checks++;
        if (tick !== 4'h0) begin
          errors++;
          $display("FAIL hold_tick cyc%0d: tick=%b required 0000", k, tick);
        end
      end
    end
    ena = 1'b1;
  endtask

  task automatic test_reset_pending();
    do_write(3, 7);
    checks++;
    if (cfg_ready !== exp_ready()) begin
      errors++;
      $display("FAIL pend_ready: ready=%b required %b", cfg_ready, exp_ready());
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({clk_div, tick, Y, cfg_ready} !== {4'h0, 4'h0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: clk_div=%b tick=%b Y=%b ready=%b required 0000 0000 0 1",
               clk_div, tick, Y, cfg_ready);
    end
    model_reset();
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      checks++;
      if ({clk_div, tick, Y, cfg_ready} !== {e_clk, e_tick, e_y, 1'b1}) begin
        errors++;
        $display("FAIL post_reset cyc%0d: clk_div=%b tick=%b Y=%b ready=%b required %b %b %b 1",
                 k, clk_div, tick, Y, cfg_ready, e_clk, e_tick, e_y);
      end
    end
  endtask

  task automatic test_combine();
    int highs, n;
    do_write(2, 8);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 40) begin cyc(); n++; end
    checks++;
    if (n == 40) begin
      errors++;
      $display("FAIL comb_apply: ready=%b required 1 within 40 cycles", cfg_ready);
    end
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (Y === 1'b1) highs++;
      checks++;
      if ({clk_div, tick, Y} !== {e_clk, e_tick, e_y}) begin
        errors++;
        $display("FAIL comb_out cyc%0d: clk_div=%b tick=%b Y=%b required %b %b %b",
                 k, clk_div, tick, Y, e_clk, e_tick, e_y);
      end
    end
    checks++;
`ifdef CLKDIV_COMBINE_EN
    if (highs != 4) begin
`else
    if (highs != 0) begin
`endif
      errors++;
      $display("FAIL comb_count: Y high %0d cycles of 16", highs);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ena       = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_chan  = CW'($urandom_range(0, CH - 1));
      cfg_div   = DW'($urandom_range(0, 9));
      checks++;
      if (cfg_ready !== exp_ready()) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: ready=%b required %b", k, cfg_ready, exp_ready());
      end
      cyc();
      checks++;
      if ({clk_div, tick, Y} !== {e_clk, e_tick, e_y}) begin
        errors++;
        $display("FAIL rand_out cyc%0d: clk_div=%b tick=%b Y=%b required %b %b %b",
                 k, clk_div, tick, Y, e_clk, e_tick, e_y);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_div2();
    test_write_d3();
    test_off_and_d1();
    test_ena_hold();
    test_reset_pending();
    test_combine();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
